// File: rtl/easyaxi_mst_ost.sv
// ---------------------------------------------------------------------------
// easyaxi_mst_ost
//   AXI read master with up to OST_DEPTH outstanding transactions.
//   Commands are accepted into the lowest free tracking slot. AR requests are
//   issued one at a time in round-robin slot order. R beats are matched back
//   to slots by the low IDX_W bits of RID, and every completed transaction
//   reports its slot and an error flag.
//
//   Optional build macro: EASYAXI_MST_RLAST_CHK_EN
//     When defined, each beat count is checked against len+1. An early or
//     missing RLAST marks the transaction as errored, and a missing RLAST
//     still completes the slot at beat len+1.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   cmd_valid/ready/addr/len: command port (len = burst length minus one)
//   axi_mst_ar*             : AXI read address channel
//   axi_mst_r*              : AXI read data channel (rready is tied high)
//   rd_data_vld, rd_data    : registered copy of each accepted beat
//   rd_done, rd_done_id,
//   rd_done_err             : one-cycle completion pulse with slot and status
//   ost_cnt                 : number of occupied slots
//   err_unexp               : sticky flag for a beat with no pending slot
// ---------------------------------------------------------------------------
module easyaxi_mst_ost #(
    parameter int         OST_DEPTH = 4,
    parameter int         IDX_W     = 2,
    parameter int         ID_W      = 4,
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter int         LEN_W     = 8,
    parameter logic [2:0] SIZE_VAL  = 3'b010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              axi_mst_arvalid,
    input  logic              axi_mst_arready,
    output logic [ID_W-1:0]   axi_mst_arid,
    output logic [ADDR_W-1:0] axi_mst_araddr,
    output logic [LEN_W-1:0]  axi_mst_arlen,
    output logic [2:0]        axi_mst_arsize,
    output logic [1:0]        axi_mst_arburst,
    input  logic              axi_mst_rvalid,
    output logic              axi_mst_rready,
    input  logic [ID_W-1:0]   axi_mst_rid,
    input  logic [DATA_W-1:0] axi_mst_rdata,
    input  logic [1:0]        axi_mst_rresp,
    input  logic              axi_mst_rlast,
    output logic              rd_data_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_done,
    output logic [IDX_W-1:0]  rd_done_id,
    output logic              rd_done_err,
    output logic [IDX_W:0]    ost_cnt,
    output logic              err_unexp
);

    typedef enum logic {AR_IDLE = 1'b0, AR_VALID = 1'b1} ar_state_t;

    ar_state_t         ar_state_q, ar_state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  ar_idx_q, ar_idx_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d;
    logic              ar_hs;

    logic [OST_DEPTH-1:0] valid_vec, req_vec, comp_vec, free_vec, done_vec, err_acc_vec;
    logic [ADDR_W-1:0]    addr_arr [OST_DEPTH];
    logic [LEN_W-1:0]     len_arr  [OST_DEPTH];

    logic [IDX_W-1:0] alloc_idx, sel_idx, cand;
    logic             alloc_en, sel_found;
    logic [IDX_W-1:0] r_slot;
    logic             r_id_ok, r_hit;
    logic [IDX_W:0]   free_cnt;

    logic              rd_data_vld_q, rd_data_vld_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_done_q, rd_done_d;
    logic [IDX_W-1:0]  rd_done_id_q, rd_done_id_d;
    logic              rd_done_err_q, rd_done_err_d;
    logic [IDX_W:0]    ost_cnt_q, ost_cnt_d;
    logic              err_unexp_q, err_unexp_d;

    // ---------------- allocation: lowest-index free slot ----------------
    assign cmd_ready = ~&valid_vec;
    assign alloc_en  = cmd_valid & cmd_ready;

    always_comb begin
        alloc_idx = '0;
        for (int i = OST_DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) alloc_idx = IDX_W'(i);
        end
    end

    // ---------------- AR stage ----------------
    // First pending request at or after rr_ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < OST_DEPTH; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % OST_DEPTH);
            if (!sel_found && req_vec[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ar_state_q <= AR_IDLE;
        else     ar_state_q <= ar_state_d;
    end

    always_comb begin
        ar_state_d = ar_state_q;
        case (ar_state_q)
            AR_IDLE:  if (sel_found)       ar_state_d = AR_VALID;
            AR_VALID: if (axi_mst_arready) ar_state_d = AR_IDLE;
            default:                       ar_state_d = AR_IDLE;
        endcase
    end

    always_comb begin
        axi_mst_arvalid = (ar_state_q == AR_VALID);
        ar_hs           = axi_mst_arvalid & axi_mst_arready;
    end

    // Payload is only loaded from idle, so it holds while arvalid & ~arready.
    always_comb begin
        ar_idx_d = ar_idx_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        rr_ptr_d = rr_ptr_q;
        if (ar_state_q == AR_IDLE && sel_found) begin
            ar_idx_d = sel_idx;
            araddr_d = addr_arr[sel_idx];
            arlen_d  = len_arr[sel_idx];
        end
        if (ar_hs) begin
            rr_ptr_d = (ar_idx_q == IDX_W'(OST_DEPTH - 1)) ? '0 : ar_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_idx_q <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            ar_idx_q <= ar_idx_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign axi_mst_arid    = ID_W'(ar_idx_q);
    assign axi_mst_araddr  = araddr_q;
    assign axi_mst_arlen   = arlen_q;
    assign axi_mst_arsize  = SIZE_VAL;
    assign axi_mst_arburst = 2'b01;
    assign axi_mst_rready  = 1'b1;

    // ---------------- R stage: slot lookup ----------------
    assign r_slot  = axi_mst_rid[IDX_W-1:0];
    assign r_id_ok = ((axi_mst_rid >> IDX_W) == '0) && (int'(r_slot) < OST_DEPTH);
    assign r_hit   = axi_mst_rvalid & r_id_ok & comp_vec[r_slot];

    // ---------------- per-slot tracking state ----------------
    for (genvar gi = 0; gi < OST_DEPTH; gi++) begin : g_slot
        logic              valid_q, valid_d, req_q, req_d, comp_q, comp_d, err_q, err_d;
        logic [LEN_W:0]    beat_q, beat_d;
        logic [ADDR_W-1:0] addr_q, addr_d;
        logic [LEN_W-1:0]  len_q, len_d;
        logic              alloc_sel, grant_clr, r_sel, beat_bad, beat_end, beat_err;
        logic [LEN_W:0]    beat_inc;

        assign alloc_sel = alloc_en && (alloc_idx == IDX_W'(gi));
        assign grant_clr = ar_hs && (ar_idx_q == IDX_W'(gi));
        assign r_sel     = r_hit && (r_slot == IDX_W'(gi));
        assign beat_inc  = beat_q + {{LEN_W{1'b0}}, 1'b1};

`ifdef EASYAXI_MST_RLAST_CHK_EN
        logic len_hit;
        assign len_hit  = (beat_inc == ({1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1}));
        assign beat_bad = axi_mst_rlast ^ len_hit;   // early or missing rlast
        assign beat_end = axi_mst_rlast | len_hit;
`else
        assign beat_bad = 1'b0;
        assign beat_end = axi_mst_rlast;
`endif

        assign beat_err = err_q | (axi_mst_rresp != 2'b00) | beat_bad;

        always_comb begin
            valid_d = valid_q;
            req_d   = req_q;
            comp_d  = comp_q;
            err_d   = err_q;
            beat_d  = beat_q;
            addr_d  = addr_q;
            len_d   = len_q;
            // Retire a finished slot; it becomes allocatable next cycle.
            if (valid_q && !req_q && !comp_q) valid_d = 1'b0;
            if (grant_clr) req_d = 1'b0;
            if (r_sel) begin
                beat_d = beat_inc;
                err_d  = beat_err;
                if (beat_end) comp_d = 1'b0;
            end
            if (alloc_sel) begin
                valid_d = 1'b1;
                req_d   = 1'b1;
                comp_d  = 1'b1;
                err_d   = 1'b0;
                beat_d  = '0;
                addr_d  = cmd_addr;
                len_d   = cmd_len;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                req_q   <= 1'b0;
                comp_q  <= 1'b0;
                err_q   <= 1'b0;
                beat_q  <= '0;
                addr_q  <= '0;
                len_q   <= '0;
            end else begin
                valid_q <= valid_d;
                req_q   <= req_d;
                comp_q  <= comp_d;
                err_q   <= err_d;
                beat_q  <= beat_d;
                addr_q  <= addr_d;
                len_q   <= len_d;
            end
        end

        assign valid_vec[gi]   = valid_q;
        assign req_vec[gi]     = req_q;
        assign comp_vec[gi]    = comp_q;
        assign free_vec[gi]    = valid_q & ~req_q & ~comp_q;
        assign done_vec[gi]    = r_sel & beat_end;
        assign err_acc_vec[gi] = beat_err;
        assign addr_arr[gi]    = addr_q;
        assign len_arr[gi]     = len_q;
    end

    // ---------------- status outputs ----------------
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < OST_DEPTH; i++) begin
            free_cnt = free_cnt + (IDX_W + 1)'(free_vec[i]);
        end
    end

    always_comb begin
        rd_data_vld_d = r_hit;
        rd_data_d     = r_hit ? axi_mst_rdata : rd_data_q;
        rd_done_d     = |done_vec;
        rd_done_id_d  = (|done_vec) ? r_slot : rd_done_id_q;
        rd_done_err_d = (|done_vec) ? err_acc_vec[r_slot] : 1'b0;
        ost_cnt_d     = ost_cnt_q + (IDX_W + 1)'(alloc_en) - free_cnt;
        err_unexp_d   = err_unexp_q | (axi_mst_rvalid & ~r_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_vld_q <= 1'b0;
            rd_data_q     <= '0;
            rd_done_q     <= 1'b0;
            rd_done_id_q  <= '0;
            rd_done_err_q <= 1'b0;
            ost_cnt_q     <= '0;
            err_unexp_q   <= 1'b0;
        end else begin
            rd_data_vld_q <= rd_data_vld_d;
            rd_data_q     <= rd_data_d;
            rd_done_q     <= rd_done_d;
            rd_done_id_q  <= rd_done_id_d;
            rd_done_err_q <= rd_done_err_d;
            ost_cnt_q     <= ost_cnt_d;
            err_unexp_q   <= err_unexp_d;
        end
    end

    assign rd_data_vld = rd_data_vld_q;
    assign rd_data     = rd_data_q;
    assign rd_done     = rd_done_q;
    assign rd_done_id  = rd_done_id_q;
    assign rd_done_err = rd_done_err_q;
    assign ost_cnt     = ost_cnt_q;
    assign err_unexp   = err_unexp_q;

endmodule

// File: tb/tb_easyaxi_mst_ost.sv
// ---------------------------------------------------------------------------
// tb_easyaxi_mst_ost
//   Directed testbench for easyaxi_mst_ost with default parameters.
//   Inputs are driven 1 ns after the rising edge, outputs sampled on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_easyaxi_mst_ost;

    localparam int OST_DEPTH = 4;
    localparam int IDX_W     = 2;
    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              axi_mst_arvalid;
    logic              axi_mst_arready = 1'b0;
    logic [ID_W-1:0]   axi_mst_arid;
    logic [ADDR_W-1:0] axi_mst_araddr;
    logic [LEN_W-1:0]  axi_mst_arlen;
    logic [2:0]        axi_mst_arsize;
    logic [1:0]        axi_mst_arburst;
    logic              axi_mst_rvalid = 1'b0;
    logic              axi_mst_rready;
    logic [ID_W-1:0]   axi_mst_rid = '0;
    logic [DATA_W-1:0] axi_mst_rdata = '0;
    logic [1:0]        axi_mst_rresp = '0;
    logic              axi_mst_rlast = 1'b0;
    logic              rd_data_vld;
    logic [DATA_W-1:0] rd_data;
    logic              rd_done;
    logic [IDX_W-1:0]  rd_done_id;
    logic              rd_done_err;
    logic [IDX_W:0]    ost_cnt;
    logic              err_unexp;

    always #5 clk = ~clk;

    easyaxi_mst_ost #(
        .OST_DEPTH(OST_DEPTH), .IDX_W(IDX_W), .ID_W(ID_W),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SIZE_VAL(3'b010)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .axi_mst_arvalid(axi_mst_arvalid), .axi_mst_arready(axi_mst_arready),
        .axi_mst_arid(axi_mst_arid), .axi_mst_araddr(axi_mst_araddr),
        .axi_mst_arlen(axi_mst_arlen), .axi_mst_arsize(axi_mst_arsize),
        .axi_mst_arburst(axi_mst_arburst),
        .axi_mst_rvalid(axi_mst_rvalid), .axi_mst_rready(axi_mst_rready),
        .axi_mst_rid(axi_mst_rid), .axi_mst_rdata(axi_mst_rdata),
        .axi_mst_rresp(axi_mst_rresp), .axi_mst_rlast(axi_mst_rlast),
        .rd_data_vld(rd_data_vld), .rd_data(rd_data),
        .rd_done(rd_done), .rd_done_id(rd_done_id), .rd_done_err(rd_done_err),
        .ost_cnt(ost_cnt), .err_unexp(err_unexp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Event monitor: records completions, data beats and AR handshakes.
    int                done_ids[$];
    int                done_errs[$];
    int                ar_ids[$];
    int                vld_cnt = 0;
    logic [DATA_W-1:0] last_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_done) begin
                done_ids.push_back(int'(rd_done_id));
                done_errs.push_back(int'(rd_done_err));
            end
            if (rd_data_vld) begin
                vld_cnt++;
                last_data = rd_data;
            end
            if (axi_mst_arvalid && axi_mst_arready) ar_ids.push_back(int'(axi_mst_arid));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        done_ids.delete();
        done_errs.delete();
        ar_ids.delete();
        vld_cnt = 0;
    endtask

    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        bit acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1'b1;
            sync();
        end
        cmd_valid = 1'b0;
        check("cmd_accept", acc, 1);
    endtask

    task automatic r_beat(input int id, input logic [DATA_W-1:0] d,
                          input logic [1:0] resp, input logic last);
        axi_mst_rvalid = 1'b1;
        axi_mst_rid    = ID_W'(id);
        axi_mst_rdata  = d;
        axi_mst_rresp  = resp;
        axi_mst_rlast  = last;
        sync();
        axi_mst_rvalid = 1'b0;
        axi_mst_rlast  = 1'b0;
        axi_mst_rresp  = 2'b00;
    endtask

    task automatic check_done(input string tag, input int idx, input int id, input int err);
        check({tag, "_present"}, done_ids.size() > idx, 1);
        if (done_ids.size() > idx) begin
            check({tag, "_id"}, done_ids[idx], id);
            check({tag, "_err"}, done_errs[idx], err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_chk_err;
        bit got_ready;

        // ---------------- reset state ----------------
        step(3);
        @(negedge clk);
        check("rst_arvalid", axi_mst_arvalid, 0);
        check("rst_ost_cnt", ost_cnt, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_rd_data_vld", rd_data_vld, 0);
        check("rst_err_unexp", err_unexp, 0);
        check("rst_rready", axi_mst_rready, 1);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        sync();

        // ---------------- single read, latency N+2 ----------------
        axi_mst_arready = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h100;
        cmd_len   = 8'd3;
        @(negedge clk);
        check("t1_cmd_ready", cmd_ready, 1);
        sync();                       // accepted on this edge (cycle N)
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t1_arvalid_n1", axi_mst_arvalid, 0);
        check("t1_ost_cnt_1", ost_cnt, 1);
        sync();
        @(negedge clk);
        check("t1_arvalid_n2", axi_mst_arvalid, 1);
        check("t1_arid", axi_mst_arid, 0);
        check("t1_araddr", axi_mst_araddr, 32'h100);
        check("t1_arlen", axi_mst_arlen, 3);
        check("t1_arsize", axi_mst_arsize, 3'b010);
        check("t1_arburst", axi_mst_arburst, 2'b01);
        sync();
        for (int b = 0; b < 4; b++) r_beat(0, 32'hA0 + b, 2'b00, b == 3);
        step(3);
        @(negedge clk);
        check("t1_vld_cnt", vld_cnt, 4);
        check("t1_last_data", last_data, 32'hA3);
        check("t1_done_cnt", done_ids.size(), 1);
        check_done("t1_done", 0, 0, 0);
        check("t1_ost_cnt_0", ost_cnt, 0);
        sync();

        // ---------------- fill with arready low ----------------
        clr();
        axi_mst_arready = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(32'h200 + 32'(16 * i), 8'd0);
        @(negedge clk);
        check("t2_cmd_ready_full", cmd_ready, 0);
        check("t2_ost_cnt_4", ost_cnt, 4);
        check("t2_arvalid_hold", axi_mst_arvalid, 1);
        check("t2_arid_hold", axi_mst_arid, 0);
        check("t2_araddr_hold", axi_mst_araddr, 32'h200);
        sync();
        cmd_valid = 1'b1;             // fifth command must stall
        cmd_addr  = 32'h300;
        cmd_len   = 8'd0;
        step(3);
        @(negedge clk);
        check("t2_stall_ready", cmd_ready, 0);
        check("t2_stall_cnt", ost_cnt, 4);
        sync();
        axi_mst_arready = 1'b1;
        step(10);
        check("t2_ar_cnt4", ar_ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (ar_ids.size() > i) check($sformatf("t2_ar_order_%0d", i), ar_ids[i], i);
        end
        fork
            begin
                got_ready = 1'b0;
                for (int k = 0; k < 40 && !got_ready; k++) begin
                    @(negedge clk);
                    if (cmd_ready) got_ready = 1'b1;
                    sync();
                end
                cmd_valid = 1'b0;
                check("t2_fifth_accept", got_ready, 1);
            end
            begin
                for (int i = 0; i < 4; i++) r_beat(i, 32'hB0 + 32'(i), 2'b00, 1'b1);
            end
        join
        step(8);
        r_beat(0, 32'hC0, 2'b00, 1'b1);
        step(3);
        check("t2_ar_cnt5", ar_ids.size(), 5);
        if (ar_ids.size() > 4) check("t2_ar_wrap_id", ar_ids[4], 0);
        for (int i = 0; i < 4; i++) check_done($sformatf("t2_done%0d", i), i, i, 0);
        check_done("t2_done4", 4, 0, 0);
        @(negedge clk);
        check("t2_ost_cnt_0", ost_cnt, 0);
        sync();

        // ---------------- out-of-order completion ----------------
        clr();
        send_cmd(32'h400, 8'd0);
        send_cmd(32'h410, 8'd0);
        send_cmd(32'h420, 8'd0);
        step(8);
        check("t3_ar_cnt", ar_ids.size(), 3);
        r_beat(2, 32'hD2, 2'b00, 1'b1);
        step(3);
        send_cmd(32'h430, 8'd0);      // slots 0,1 busy: lands in slot 2
        step(6);
        check("t3_ar_cnt4", ar_ids.size(), 4);
        if (ar_ids.size() > 3) check("t3_realloc_id", ar_ids[3], 2);
        r_beat(0, 32'hD0, 2'b00, 1'b1);
        r_beat(1, 32'hD1, 2'b00, 1'b1);
        r_beat(2, 32'hD3, 2'b00, 1'b1);
        step(3);
        check_done("t3_done0", 0, 2, 0);
        check_done("t3_done1", 1, 0, 0);
        check_done("t3_done2", 2, 1, 0);
        check_done("t3_done3", 3, 2, 0);
        check("t3_last_data", last_data, 32'hD3);
        @(negedge clk);
        check("t3_ost_cnt_0", ost_cnt, 0);
        sync();

        // ---------------- error response ----------------
        clr();
        send_cmd(32'h500, 8'd3);
        send_cmd(32'h510, 8'd0);
        step(6);
        r_beat(0, 32'hE0, 2'b00, 1'b0);
        r_beat(0, 32'hE1, 2'b10, 1'b0);
        r_beat(0, 32'hE2, 2'b00, 1'b0);
        r_beat(0, 32'hE3, 2'b00, 1'b1);
        r_beat(1, 32'hE4, 2'b00, 1'b1);
        step(3);
        check("t4_done_cnt", done_ids.size(), 2);
        check_done("t4_slot0", 0, 0, 1);
        check_done("t4_slot1", 1, 1, 0);
        check("t4_vld_cnt", vld_cnt, 5);
        check("t4_err_unexp", err_unexp, 0);

        // ---------------- unexpected beat ----------------
        clr();
        r_beat(3, 32'hF0, 2'b00, 1'b1);
        step(2);
        @(negedge clk);
        check("t5_err_unexp", err_unexp, 1);
        check("t5_no_done", done_ids.size(), 0);
        check("t5_no_vld", vld_cnt, 0);
        sync();

        // ---------------- asynchronous reset mid-transaction ----------------
        axi_mst_arready = 1'b0;
        send_cmd(32'h600, 8'd1);
        step(2);
        @(negedge clk);
        check("t5_arvalid_pre", axi_mst_arvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_arvalid_async", axi_mst_arvalid, 0);
        check("t5_ost_cnt_rst", ost_cnt, 0);
        check("t5_err_unexp_rst", err_unexp, 0);
        check("t5_rd_done_rst", rd_done, 0);
        check("t5_cmd_ready_rst", cmd_ready, 1);
        sync();
        sync();
        rst = 1'b0;
        axi_mst_arready = 1'b1;
        r_beat(0, 32'hF1, 2'b00, 1'b1);   // late beat for a dropped slot
        step(2);
        @(negedge clk);
        check("t5_late_unexp", err_unexp, 1);
        check("t5_no_ar", axi_mst_arvalid, 0);
        sync();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        sync();

        // ---------------- early rlast ----------------
        clr();
        send_cmd(32'h700, 8'd3);
        step(5);
        r_beat(0, 32'h70, 2'b00, 1'b0);
        r_beat(0, 32'h71, 2'b00, 1'b1);
        step(3);
`ifdef EASYAXI_MST_RLAST_CHK_EN
        exp_chk_err = 1;
`else
        exp_chk_err = 0;
`endif
        check("t6_done_cnt", done_ids.size(), 1);
        check_done("t6_early_rlast", 0, 0, exp_chk_err);
        @(negedge clk);
        check("t6_ost_cnt_0", ost_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
